dmem_responder: RTL and testbench

//  Responder end of the MIPS core's data-memory interface: a word-organised

---
 rtl/dmem_responder.sv | 144 ++++++++++++++
 tb/tb_dmem_responder.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_responder.sv
// Word-organised data memory responder with a valid/ready request channel,
// programmable wait states and an error response for bad addresses.
module dmem_responder #(
   parameter int          DEPTH       = 256,
   parameter int          WAIT_STATES = 1,
   parameter logic [31:0] BASE_ADDR   = 32'h0
) (
   input  logic        clka,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [3:0]  req_be,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [1:0]  dbg_state
);

   // Handshake: a request transfers on an edge where req_valid && req_ready;
   // a response transfers on an edge where rsp_valid && rsp_ready. The
   // initiator holds the request stable until it transfers.

   localparam int          AW       = $clog2(DEPTH);
   localparam logic [31:0] SPAN     = 32'(DEPTH * 4);
   localparam logic [3:0]  CNT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_WAIT = 2'd1;
   localparam logic [1:0] ST_RESP = 2'd2;

   logic [1:0]  state_q, state_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [3:0]  be_q, be_d;
   logic [31:0] addr_q, addr_d;
   logic [31:0] wdata_q, wdata_d;
   logic [31:0] rdata_q, rdata_d;
   logic        err_q, err_d;

   logic [31:0] mem_q [DEPTH];

   logic [3:0]    acc_be;
   logic [31:0]   acc_addr;
   logic [31:0]   acc_wdata;
   logic [31:0]   offset;
   logic          acc_err;
   logic          access;
   logic          mem_we;
   logic [AW-1:0] idx;

   always_comb begin
      // With no wait states the access happens on the accept edge itself,
      // so the live request is used instead of the captured copy.
      acc_be    = (WAIT_STATES == 0) ? req_be    : be_q;
      acc_addr  = (WAIT_STATES == 0) ? req_addr  : addr_q;
      acc_wdata = (WAIT_STATES == 0) ? req_wdata : wdata_q;
      offset    = acc_addr - BASE_ADDR;
      acc_err   = (acc_addr[1:0] != 2'b00) || (acc_addr < BASE_ADDR) || (offset >= SPAN);
      idx       = offset[AW+1:2];

      state_d = state_q;
      cnt_d   = cnt_q;
      be_d    = be_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      rdata_d = rdata_q;
      err_d   = err_q;
      access  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (req_valid) begin
               be_d    = req_be;
               addr_d  = req_addr;
               wdata_d = req_wdata;
               if (WAIT_STATES == 0) begin
                  access  = 1'b1;
                  state_d = ST_RESP;
               end else begin
                  cnt_d   = CNT_INIT;
                  state_d = ST_WAIT;
               end
            end
         end
         ST_WAIT: begin
            if (cnt_q == 4'd0) begin
               access  = 1'b1;
               state_d = ST_RESP;
            end else begin
               cnt_d = cnt_q - 4'd1;
            end
         end
         ST_RESP: begin
            if (rsp_ready) state_d = ST_IDLE;
         end
         default: state_d = ST_IDLE;
      endcase

      if (access) begin
         err_d   = acc_err;
         rdata_d = acc_err ? 32'h0 : mem_q[idx];
      end

      mem_we = access && !acc_err && !rst;
   end

   always_ff @(posedge clka) begin
      if (rst) begin
         state_q <= ST_IDLE;
         cnt_q   <= 4'd0;
         rdata_q <= 32'h0;
         err_q   <= 1'b0;
         be_q    <= 4'h0;
         addr_q  <= 32'h0;
         wdata_q <= 32'h0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         rdata_q <= rdata_d;
         err_q   <= err_d;
         be_q    <= be_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   // Memory contents survive reset.
   always_ff @(posedge clka) begin
      if (mem_we) begin
         for (int i = 0; i < 4; i++) begin
            if (acc_be[i]) mem_q[idx][8*i +: 8] <= acc_wdata[8*i +: 8];
         end
      end
   end

   assign req_ready = (state_q == ST_IDLE);
   assign rsp_valid = (state_q == ST_RESP);
   assign rsp_rdata = rdata_q;
   assign rsp_err   = err_q;
   assign dbg_state = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances (WS=1, WS=0, WS=3 with
// BASE_ADDR=0x1000) checked against a word model through an expected queue.
module tb_dmem_responder;

   logic        clka = 1'b0;
   logic        rst       [3];
   logic        req_valid [3];
   logic        req_ready [3];
   logic [3:0]  req_be    [3];
   logic [31:0] req_addr  [3];
   logic [31:0] req_wdata [3];
   logic        rsp_valid [3];
   logic        rsp_ready [3];
   logic [31:0] rsp_rdata [3];
   logic        rsp_err   [3];
   logic [1:0]  dbg_state [3];

   int tests = 0;
   int fails = 0;
   int cyc   = 0;

   // {rdata_known, err, rdata}
   logic [33:0] exp_q[$];
   logic [31:0] mmem   [3][256];
   logic        mknown [3][256];

   always #5 clka = ~clka;
   always @(posedge clka) cyc <= cyc + 1;

   dmem_responder #(.DEPTH(256), .WAIT_STATES(1), .BASE_ADDR(32'h0)) u_ws1 (
      .clka(clka), .rst(rst[0]), .req_valid(req_valid[0]), .req_ready(req_ready[0]),
      .req_be(req_be[0]), .req_addr(req_addr[0]), .req_wdata(req_wdata[0]),
      .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
      .rsp_err(rsp_err[0]), .dbg_state(dbg_state[0]));

   dmem_responder #(.DEPTH(256), .WAIT_STATES(0), .BASE_ADDR(32'h0)) u_ws0 (
      .clka(clka), .rst(rst[1]), .req_valid(req_valid[1]), .req_ready(req_ready[1]),
      .req_be(req_be[1]), .req_addr(req_addr[1]), .req_wdata(req_wdata[1]),
      .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
      .rsp_err(rsp_err[1]), .dbg_state(dbg_state[1]));

   dmem_responder #(.DEPTH(256), .WAIT_STATES(3), .BASE_ADDR(32'h1000)) u_ws3 (
      .clka(clka), .rst(rst[2]), .req_valid(req_valid[2]), .req_ready(req_ready[2]),
      .req_be(req_be[2]), .req_addr(req_addr[2]), .req_wdata(req_wdata[2]),
      .rsp_valid(rsp_valid[2]), .rsp_ready(rsp_ready[2]), .rsp_rdata(rsp_rdata[2]),
      .rsp_err(rsp_err[2]), .dbg_state(dbg_state[2]));

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_access(input int d, input logic [3:0] be, input logic [31:0] addr,
                               input logic [31:0] wdata, output logic [33:0] r);
      logic [31:0] base;
      logic [31:0] off;
      int          w;
      base = (d == 2) ? 32'h1000 : 32'h0;
      off  = addr - base;
      if (addr[1:0] != 2'b00 || addr < base || off >= 32'd1024) begin
         r = {1'b1, 1'b1, 32'h0};
      end else begin
         w = int'(off[9:2]);
         r = {mknown[d][w], 1'b0, mmem[d][w]};
         for (int i = 0; i < 4; i++) begin
            if (be[i]) mmem[d][w][8*i +: 8] = wdata[8*i +: 8];
         end
         if (be == 4'hF) mknown[d][w] = 1'b1;
      end
   endtask

   task automatic compare_rsp(input int d);
      logic [33:0] e;
      if (exp_q.size() == 0) begin
         check("unexpected_rsp", 64'd1, 64'd0);
      end else begin
         e = exp_q.pop_front();
         check("rsp_err", 64'(rsp_err[d]), 64'(e[32]));
         if (e[33]) check("rsp_rdata", 64'(rsp_rdata[d]), 64'(e[31:0]));
      end
   endtask

   task automatic send(input int d, input logic [3:0] be, input logic [31:0] addr,
                       input logic [31:0] wdata, input bit record, output int acc);
      logic [33:0] r;
      int n;
      @(negedge clka);
      req_be[d]    = be;
      req_addr[d]  = addr;
      req_wdata[d] = wdata;
      req_valid[d] = 1'b1;
      n = 0;
      while (!req_ready[d] && n < 50) begin
         @(negedge clka);
         n++;
      end
      if (!req_ready[d]) begin
         check("req_ready_timeout", 64'd0, 64'd1);
         acc = -1;
      end else begin
         @(posedge clka);
         #1;
         acc = cyc;
         if (record) begin
            model_access(d, be, addr, wdata, r);
            exp_q.push_back(r);
         end
      end
      req_valid[d] = 1'b0;
   endtask

   task automatic wait_rsp(input int d, input int hold, output int seen);
      int n;
      logic [31:0] held_rdata;
      logic        held_err;
      @(negedge clka);
      n = 0;
      while (!rsp_valid[d] && n < 50) begin
         @(negedge clka);
         n++;
      end
      seen = cyc;
      if (!rsp_valid[d]) begin
         check("rsp_valid_timeout", 64'd0, 64'd1);
      end else begin
         compare_rsp(d);
         held_rdata = rsp_rdata[d];
         held_err   = rsp_err[d];
         for (int i = 0; i < hold; i++) begin
            @(negedge clka);
            check("hold_rsp_valid", 64'(rsp_valid[d]), 64'd1);
            check("hold_rsp_rdata", 64'(rsp_rdata[d]), 64'(held_rdata));
            check("hold_rsp_err", 64'(rsp_err[d]), 64'(held_err));
            check("hold_req_ready", 64'(req_ready[d]), 64'd0);
         end
         rsp_ready[d] = 1'b1;
         @(posedge clka);
         #1;
         rsp_ready[d] = 1'b0;
         @(negedge clka);
         check("post_rsp_valid", 64'(rsp_valid[d]), 64'd0);
         check("post_req_ready", 64'(req_ready[d]), 64'd1);
      end
   endtask

   task automatic txn(input int d, input logic [3:0] be, input logic [31:0] addr,
                      input logic [31:0] wdata, input int hold, output int lat);
      int acc;
      int seen;
      send(d, be, addr, wdata, 1'b1, acc);
      wait_rsp(d, hold, seen);
      lat = seen - acc + 1;
   endtask

   // Reads streamed with rsp_ready tied high; returns accept-edge spacing.
   task automatic back_to_back(input int d, input logic [31:0] addr, input int period);
      int          acc [3];
      int          n_acc;
      int          n_rsp;
      logic [33:0] r;
      n_acc = 0;
      n_rsp = 0;
      @(negedge clka);
      rsp_ready[d] = 1'b1;
      req_be[d]    = 4'h0;
      req_addr[d]  = addr;
      req_wdata[d] = 32'h0;
      req_valid[d] = 1'b1;
      for (int k = 0; k < 60 && !(n_acc == 3 && n_rsp == 3); k++) begin
         if (rsp_valid[d]) begin
            compare_rsp(d);
            n_rsp++;
         end
         if (req_ready[d] && req_valid[d] && n_acc < 3) begin
            acc[n_acc] = cyc + 1;
            model_access(d, 4'h0, addr, 32'h0, r);
            exp_q.push_back(r);
            n_acc++;
         end
         @(posedge clka);
         #1;
         if (n_acc == 3) req_valid[d] = 1'b0;
         @(negedge clka);
      end
      req_valid[d] = 1'b0;
      rsp_ready[d] = 1'b0;
      check("b2b_accepts", 64'(n_acc), 64'd3);
      check("b2b_responses", 64'(n_rsp), 64'd3);
      if (n_acc == 3) begin
         check("b2b_period_0", 64'(acc[1] - acc[0]), 64'(period));
         check("b2b_period_1", 64'(acc[2] - acc[1]), 64'(period));
      end
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int acc;
      for (int d = 0; d < 3; d++) begin
         rst[d]       = 1'b1;
         req_valid[d] = 1'b0;
         req_be[d]    = 4'h0;
         req_addr[d]  = 32'h0;
         req_wdata[d] = 32'h0;
         rsp_ready[d] = 1'b0;
         for (int w = 0; w < 256; w++) begin
            mmem[d][w]   = 32'h0;
            mknown[d][w] = 1'b0;
         end
      end
      repeat (2) @(posedge clka);
      #1;
      for (int d = 0; d < 3; d++) rst[d] = 1'b0;
      @(negedge clka);
      for (int d = 0; d < 3; d++) begin
         check("reset_req_ready", 64'(req_ready[d]), 64'd1);
         check("reset_rsp_valid", 64'(rsp_valid[d]), 64'd0);
         check("reset_rsp_rdata", 64'(rsp_rdata[d]), 64'd0);
         check("reset_rsp_err", 64'(rsp_err[d]), 64'd0);
      end

      // Basic write/read and WS=1 latency
      txn(0, 4'hF, 32'h10, 32'hDEADBEEF, 0, lat);
      txn(0, 4'h0, 32'h10, 32'h0, 0, lat);
      check("ws1_latency", 64'(lat), 64'd2);

      // Byte enables
      txn(0, 4'hF, 32'h10, 32'h11223344, 0, lat);
      txn(0, 4'b0101, 32'h10, 32'hAABBCCDD, 0, lat);
      txn(0, 4'h0, 32'h10, 32'h0, 0, lat);

      // Error responses
      txn(0, 4'hF, 32'h0, 32'hCAFEF00D, 0, lat);
      txn(0, 4'h0, 32'h13, 32'h0, 0, lat);
      txn(0, 4'hF, 32'h400, 32'h12345678, 0, lat);
      txn(0, 4'h0, 32'h0, 32'h0, 0, lat);
      txn(0, 4'h0, 32'h3FC, 32'h0, 0, lat);
      txn(2, 4'h0, 32'hFFC, 32'h0, 0, lat);
      txn(2, 4'hF, 32'h13FC, 32'h0BADC0DE, 0, lat);
      txn(2, 4'h0, 32'h13FC, 32'h0, 0, lat);
      txn(2, 4'h0, 32'h1400, 32'h0, 0, lat);

      // Backpressure: response held for 5 cycles
      txn(0, 4'h0, 32'h10, 32'h0, 5, lat);
      txn(0, 4'h0, 32'h0, 32'h0, 0, lat);

      // WS=0 and WS=3 latency and throughput
      txn(1, 4'hF, 32'h8, 32'h600DF00D, 0, lat);
      txn(1, 4'h0, 32'h8, 32'h0, 0, lat);
      check("ws0_latency", 64'(lat), 64'd1);
      back_to_back(1, 32'h8, 2);
      txn(2, 4'hF, 32'h1008, 32'h87654321, 0, lat);
      txn(2, 4'h0, 32'h1008, 32'h0, 0, lat);
      check("ws3_latency", 64'(lat), 64'd4);
      back_to_back(2, 32'h1008, 5);

      // Reset during WAIT drops the write
      txn(0, 4'hF, 32'h20, 32'h5, 0, lat);
      send(0, 4'hF, 32'h20, 32'h99, 1'b0, acc);
      rst[0] = 1'b1;
      @(posedge clka);
      #1;
      rst[0] = 1'b0;
      @(negedge clka);
      check("midrst_rsp_valid", 64'(rsp_valid[0]), 64'd0);
      check("midrst_req_ready", 64'(req_ready[0]), 64'd1);
      txn(0, 4'h0, 32'h20, 32'h0, 0, lat);
      check("scoreboard_empty", 64'(exp_q.size()), 64'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
